// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU: a 2-entry skid FIFO of {result, flags, tag}
// plus a status register (last flags, sticky overflow, saturating retired-op count).
module alu_result_stage #(
  parameter int BUS_WIDTH = 32,
  parameter int TAG_WIDTH = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_opcode,
  input  logic [BUS_WIDTH-1:0] in_result,
  input  logic                 in_over,
  input  logic                 in_zero,
  input  logic                 in_greater,
  input  logic                 in_equal,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_result,
  output logic [3:0]           out_flags,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [3:0]           stat_flags,
  output logic                 stat_sticky_ovf,
  output logic [CNT_WIDTH-1:0] stat_count,
  input  logic                 flag_clr
);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b1000;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Head entry drives the outputs directly; the skid entry only fills under back-pressure.
  logic [1:0]           occ_reg;
  logic [BUS_WIDTH-1:0] head_result_reg, skid_result_reg;
  logic [3:0]           head_flags_reg, skid_flags_reg;
  logic [TAG_WIDTH-1:0] head_tag_reg, skid_tag_reg;

  logic [3:0]           stat_flags_reg;
  logic                 stat_sticky_reg;
  logic [CNT_WIDTH-1:0] stat_count_reg;

  logic       is_real_op;
  logic       over_masked;
  logic [3:0] entry_flags;
  logic       accept;
  logic       push;
  logic       pop;

  always_comb begin
    is_real_op = 1'b0;
    case (in_opcode)
      OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR: is_real_op = 1'b1;
      default:                               is_real_op = 1'b0;
    endcase
  end

  assign over_masked = in_over & ((in_opcode == OP_ADD) | (in_opcode == OP_SUB));
  assign entry_flags = {over_masked, in_zero, in_greater, in_equal};

  assign in_ready  = ~rst & (occ_reg != 2'd2);
  assign out_valid = (occ_reg != 2'd0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & is_real_op;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_reg         <= 2'd0;
      head_result_reg <= '0;
      head_flags_reg  <= '0;
      head_tag_reg    <= '0;
      skid_result_reg <= '0;
      skid_flags_reg  <= '0;
      skid_tag_reg    <= '0;
    end else begin
      case (occ_reg)
        2'd0: begin
          if (push) begin
            head_result_reg <= in_result;
            head_flags_reg  <= entry_flags;
            head_tag_reg    <= in_tag;
            occ_reg         <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_result_reg <= in_result;
            head_flags_reg  <= entry_flags;
            head_tag_reg    <= in_tag;
          end else if (push) begin
            skid_result_reg <= in_result;
            skid_flags_reg  <= entry_flags;
            skid_tag_reg    <= in_tag;
            occ_reg         <= 2'd2;
          end else if (pop) begin
            occ_reg <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_result_reg <= skid_result_reg;
            head_flags_reg  <= skid_flags_reg;
            head_tag_reg    <= skid_tag_reg;
            occ_reg         <= 2'd1;
          end
        end
        default: occ_reg <= 2'd0;
      endcase
    end
  end

  // Status tracks accepts, not pops, so branch logic sees flags without waiting on writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_flags_reg  <= '0;
      stat_sticky_reg <= 1'b0;
      stat_count_reg  <= '0;
    end else begin
      if (push) begin
        stat_flags_reg <= entry_flags;
        if (stat_count_reg != {CNT_WIDTH{1'b1}})
          stat_count_reg <= stat_count_reg + CNT_ONE;
      end
      if (push && over_masked)
        stat_sticky_reg <= 1'b1;
      else if (flag_clr)
        stat_sticky_reg <= 1'b0;
    end
  end

  assign out_result      = head_result_reg;
  assign out_flags       = head_flags_reg;
  assign out_tag         = head_tag_reg;
  assign stat_flags      = stat_flags_reg;
  assign stat_sticky_ovf = stat_sticky_reg;
  assign stat_count      = stat_count_reg;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage; a second instance with a 2-bit counter checks saturation.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_opcode;
  logic [31:0] in_result;
  logic        in_over, in_zero, in_greater, in_equal;
  logic [4:0]  in_tag;
  logic        out_ready;
  logic        flag_clr;

  logic        in_ready, out_valid, stat_sticky_ovf;
  logic [31:0] out_result;
  logic [3:0]  out_flags, stat_flags;
  logic [4:0]  out_tag;
  logic [15:0] stat_count;

  logic        b_in_ready, b_out_valid, b_sticky;
  logic [31:0] b_out_result;
  logic [3:0]  b_out_flags, b_stat_flags;
  logic [4:0]  b_out_tag;
  logic [1:0]  b_stat_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.BUS_WIDTH(32), .TAG_WIDTH(5), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_result(in_result), .in_over(in_over), .in_zero(in_zero), .in_greater(in_greater),
    .in_equal(in_equal), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag), .stat_flags(stat_flags),
    .stat_sticky_ovf(stat_sticky_ovf), .stat_count(stat_count), .flag_clr(flag_clr)
  );

  alu_result_stage #(.BUS_WIDTH(32), .TAG_WIDTH(5), .CNT_WIDTH(2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_opcode(in_opcode),
    .in_result(in_result), .in_over(in_over), .in_zero(in_zero), .in_greater(in_greater),
    .in_equal(in_equal), .in_tag(in_tag), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_result(b_out_result), .out_flags(b_out_flags), .out_tag(b_out_tag),
    .stat_flags(b_stat_flags), .stat_sticky_ovf(b_sticky), .stat_count(b_stat_count),
    .flag_clr(flag_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] res,
                       input logic [3:0] fl, input logic [4:0] tg);
    in_valid   = v;
    in_opcode  = op;
    in_result  = res;
    {in_over, in_zero, in_greater, in_equal} = fl;
    in_tag     = tg;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; flag_clr = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 4'd0, 5'd0);
    step(); step();
    // Reset state
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_stat_count", stat_count, 16'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);

    // Single ADD
    drive(1'b1, 4'b0001, 32'h5, 4'b0000, 5'd3);
    step();
    drive(1'b0, 4'd0, 32'd0, 4'd0, 5'd0);
    chk("single_valid", out_valid, 1'b1);
    chk("single_result", out_result, 32'h5);
    chk("single_tag", out_tag, 5'd3);
    chk("single_flags", out_flags, 4'b0000);
    chk("single_count", stat_count, 16'd1);
    chk("single_stat_flags", stat_flags, 4'b0000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_popped", out_valid, 1'b0);
    chk("single_hold", out_result, 32'h5);

    // Back-pressure: two accepted, third stalls
    drive(1'b1, 4'b0001, 32'd1, 4'd0, 5'd1); step();
    drive(1'b1, 4'b0001, 32'd2, 4'd0, 5'd2); step();
    drive(1'b1, 4'b0001, 32'd3, 4'd0, 5'd3);
    chk("bp_full_ready", in_ready, 1'b0);
    step();
    chk("bp_stall_valid", out_valid, 1'b1);
    chk("bp_stall_result", out_result, 32'd1);
    chk("bp_stall_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    step();
    chk("bp_out2", out_result, 32'd2);
    chk("bp_ready_again", in_ready, 1'b1);
    step();
    drive(1'b0, 4'd0, 32'd0, 4'd0, 5'd0);
    chk("bp_out3", out_result, 32'd3);
    chk("bp_out3_tag", out_tag, 5'd3);
    step();
    chk("bp_drained", out_valid, 1'b0);
    chk("bp_count", stat_count, 16'd4);

    // Full-throughput streaming
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'b0011, 32'd100 + 32'(i), 4'b0010, 5'(i));
      chk("stream_in_ready", in_ready, 1'b1);
      step();
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_result", out_result, 32'd100 + 32'(i));
    end
    drive(1'b0, 4'd0, 32'd0, 4'd0, 5'd0);
    step();
    chk("stream_drained", out_valid, 1'b0);
    chk("stream_count", stat_count, 16'd14);

    // Overflow masking and sticky behaviour
    drive(1'b1, 4'b0001, 32'd7, 4'b1000, 5'd7); step();
    chk("ovf_add_flags", out_flags, 4'b1000);
    chk("ovf_add_sticky", stat_sticky_ovf, 1'b1);
    chk("ovf_add_stat", stat_flags, 4'b1000);
    drive(1'b1, 4'b0100, 32'd8, 4'b1100, 5'd8); step();
    chk("ovf_and_flags", out_flags, 4'b0100);
    chk("ovf_and_stat", stat_flags, 4'b0100);
    chk("ovf_and_sticky", stat_sticky_ovf, 1'b1);
    drive(1'b1, 4'b0010, 32'd9, 4'b1000, 5'd9); flag_clr = 1'b1; step();
    chk("ovf_set_wins", stat_sticky_ovf, 1'b1);
    drive(1'b0, 4'd0, 32'd0, 4'd0, 5'd0); step();
    chk("ovf_clr_sticky", stat_sticky_ovf, 1'b0);
    flag_clr = 1'b0;
    chk("ovf_count", stat_count, 16'd17);

    // NUL and unknown opcodes: consumed, not enqueued, status untouched
    drive(1'b1, 4'b0000, 32'd55, 4'b0111, 5'd1);
    chk("nul_ready", in_ready, 1'b1);
    step();
    chk("nul_no_valid", out_valid, 1'b0);
    drive(1'b1, 4'b1111, 32'd56, 4'b0111, 5'd2);
    chk("unk_ready", in_ready, 1'b1);
    step();
    drive(1'b0, 4'd0, 32'd0, 4'd0, 5'd0);
    chk("unk_no_valid", out_valid, 1'b0);
    chk("nul_count", stat_count, 16'd17);
    chk("nul_stat_flags", stat_flags, 4'b1000);

    // Reset while full
    out_ready = 1'b0;
    drive(1'b1, 4'b1000, 32'd9, 4'b0001, 5'd4); step();
    drive(1'b1, 4'b1000, 32'd10, 4'b0001, 5'd5); step();
    drive(1'b0, 4'd0, 32'd0, 4'd0, 5'd0);
    chk("mid_full", in_ready, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_valid", out_valid, 1'b0);
    chk("mid_result", out_result, 32'd0);
    chk("mid_count", stat_count, 16'd0);
    chk("mid_stat_flags", stat_flags, 4'd0);
    chk("mid_sticky", stat_sticky_ovf, 1'b0);
    chk("mid_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    step();
    chk("mid_still_empty", out_valid, 1'b0);

    // Saturation on the 2-bit counter instance
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0001, 32'(i), 4'd0, 5'(i));
      step();
      if (i == 1) chk("sat_two", b_stat_count, 2'd2);
    end
    drive(1'b0, 4'd0, 32'd0, 4'd0, 5'd0);
    chk("sat_small", b_stat_count, 2'd3);
    chk("sat_wide", stat_count, 16'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
